// File: rtl/matmul_result_writer.sv
// ---------------------------------------------------------------------------
// matmul_result_writer
//
// Downstream stage of the 4x4 systolic matrix-multiply unit. Each accepted
// 128-bit beat carries four signed 32-bit lane accumulators. Every lane is
// requantized (arithmetic right shift with round-half-up, then saturation to
// signed 16-bit). The four results are packed into one 64-bit word and
// written to the shared result BRAM at consecutive addresses.
//
// Build option:
//   MATMUL_WRITER_RELU_EN - when defined, negative lanes are clamped to 0
//                           after rounding and before saturation.
//
// Ports:
//   clk        system clock, rising edge
//   n_rst      asynchronous active-low reset
//   start      one-cycle job start pulse (sampled in IDLE only)
//   base_addr  first write address of the job
//   num_rows   number of beats in the job (0 = empty job)
//   shift      right-shift amount 0..31
//   in_valid   input beat valid
//   in_ready   block accepts a beat this cycle
//   in_data    lane i = in_data[32i+31:32i], signed
//   mem_we     result memory write strobe
//   mem_addr   result memory write address
//   mem_wdata  lane i = mem_wdata[16i+15:16i]
//   busy       job in progress (RUN or DRAIN)
//   done       one-cycle completion pulse
// ---------------------------------------------------------------------------
module matmul_result_writer #(
  parameter int LANES  = 4,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [7:0]               num_rows,
  input  logic [4:0]               shift,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*ACC_W-1:0]   in_data,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [LANES*OUT_W-1:0]   mem_wdata,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] DRAIN = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  // Stage-1 arithmetic is one bit wider than the accumulator so that adding
  // the rounding constant to a near-maximum lane cannot wrap.
  localparam logic [ACC_W:0]        ONE     = {{ACC_W{1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [1:0]               state_reg;
  logic [1:0]               state_next;
  logic [7:0]               rows_reg;
  logic [4:0]               shift_reg;
  logic [7:0]               cnt_reg;
  logic [ADDR_W-1:0]        addr_reg;
  logic                     s1_valid_reg;
  logic                     mem_we_reg;
  logic [ADDR_W-1:0]        mem_addr_reg;
  logic [LANES*OUT_W-1:0]   mem_wdata_reg;
  logic [LANES*OUT_W-1:0]   wdata_next;
  logic                     accept;
  logic                     last_accept;

  // -------------------------------------------------------------------------
  // Handshake and status
  // -------------------------------------------------------------------------
  assign in_ready    = (state_reg == RUN) && (cnt_reg < rows_reg);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (cnt_reg == rows_reg - 8'd1);
  assign busy        = (state_reg == RUN) || (state_reg == DRAIN);
  assign done        = (state_reg == DONE);

  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (num_rows == 8'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_accept) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Leave only after both pipeline stages have emptied so the final
        // write is complete before done is raised.
        if (!s1_valid_reg && !mem_we_reg) begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= IDLE;
      rows_reg  <= 8'd0;
      shift_reg <= 5'd0;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && start) begin
        rows_reg  <= num_rows;
        shift_reg <= shift;
        cnt_reg   <= 8'd0;
      end else if (accept) begin
        cnt_reg <= cnt_reg + 8'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-lane requantization
  //   stage 1: round-half-up arithmetic shift (registered)
  //   stage 2: optional ReLU, saturate, pack (registered in the write regs)
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [ACC_W-1:0]      x_raw;
      logic signed [ACC_W:0] x_ext;
      logic signed [ACC_W:0] rnd;
      logic signed [ACC_W:0] r_next;
      logic signed [ACC_W:0] r_reg;
      logic signed [ACC_W:0] r_post;
      logic [OUT_W-1:0]      sat;

      assign x_raw = in_data[ACC_W*gi +: ACC_W];
      assign x_ext = $signed({x_raw[ACC_W-1], x_raw});

      // With shift == 0 the rounding term is zero and the shift is a no-op,
      // so the same expression covers the pass-through case.
      assign rnd    = (shift_reg == 5'd0) ? '0 : $signed(ONE << (shift_reg - 5'd1));
      assign r_next = (x_ext + rnd) >>> shift_reg;

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          r_reg <= '0;
        end else if (accept) begin
          r_reg <= r_next;
        end
      end

`ifdef MATMUL_WRITER_RELU_EN
      assign r_post = r_reg[ACC_W] ? '0 : r_reg;
`else
      assign r_post = r_reg;
`endif

      assign sat = (r_post > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
                   (r_post < SAT_MIN) ? SAT_MIN[OUT_W-1:0] :
                                        r_post[OUT_W-1:0];

      assign wdata_next[OUT_W*gi +: OUT_W] = sat;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Pipeline valids, write port and address counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid_reg  <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      addr_reg      <= '0;
    end else begin
      s1_valid_reg <= accept;
      mem_we_reg   <= s1_valid_reg;
      if ((state_reg == IDLE) && start) begin
        addr_reg <= base_addr;
      end else if (s1_valid_reg) begin
        // Address advances only on real writes; bubbles leave it (and the
        // held write data) untouched. 8-bit wrap is intentional.
        mem_addr_reg  <= addr_reg;
        mem_wdata_reg <= wdata_next;
        addr_reg      <= addr_reg + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_matmul_result_writer.sv
// ---------------------------------------------------------------------------
// Directed testbench for matmul_result_writer. Inputs are driven and outputs
// sampled on the falling clock edge; expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_matmul_result_writer;

  logic         clk;
  logic         n_rst;
  logic         start;
  logic [7:0]   base_addr;
  logic [7:0]   num_rows;
  logic [4:0]   shift;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         mem_we;
  logic [7:0]   mem_addr;
  logic [63:0]  mem_wdata;
  logic         busy;
  logic         done;

  int n_cmp;
  int n_err;

  matmul_result_writer dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .shift     (shift),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " in_ready"},  64'(in_ready),  64'd0);
    chk({tag, " busy"},      64'(busy),      64'd0);
    chk({tag, " done"},      64'(done),      64'd0);
    chk({tag, " mem_we"},    64'(mem_we),    64'd0);
    chk({tag, " mem_addr"},  64'(mem_addr),  64'd0);
    chk({tag, " mem_wdata"}, mem_wdata,      64'd0);
  endtask

  // Job with in_valid held high and the same beat every cycle. Start is
  // captured at edge 1, beats are accepted at edges 2..r+1, writes are
  // visible in cycles 3..r+2, done is visible in cycle r+4.
  task automatic run_job(input string tag, input logic [7:0] b, input int r,
                         input logic [4:0] s, input logic [127:0] d,
                         input logic [63:0] w);
    logic [7:0] ea;
    @(negedge clk);
    start = 1'b1; base_addr = b; num_rows = 8'(r); shift = s;
    in_valid = 1'b0; in_data = d;
    for (int c = 1; c <= r + 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      chk({tag, " busy"},     64'(busy),     64'(c <= r + 3));
      chk({tag, " in_ready"}, 64'(in_ready), 64'(c <= r));
      chk({tag, " done"},     64'(done),     64'(c == r + 4));
      chk({tag, " mem_we"},   64'(mem_we),   64'(c >= 3 && c <= r + 2));
      if (c >= 3 && c <= r + 2) begin
        ea = b + 8'(c - 3);
        chk({tag, " mem_addr"},  64'(mem_addr), 64'(ea));
        chk({tag, " mem_wdata"}, mem_wdata,     w);
      end
      if (c == r + 4) begin
        chk({tag, " wdata_hold"}, mem_wdata, w);
      end
    end
    in_valid = 1'b0;
  endtask

  logic [63:0] exp_w;
  logic [15:0] lane_v;
  logic [7:0]  ea4;

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_rst = 1'b1;
    start = 1'b0;
    base_addr = 8'd0;
    num_rows = 8'd0;
    shift = 5'd0;
    in_valid = 1'b0;
    in_data = '0;

    // ---- reset state
    #2 n_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    n_rst = 1'b1;

    // ---- basic pass-through, lanes {3,-2,1,0}
    run_job("j1", 8'h10, 4, 5'd0,
            {32'd0, 32'd1, 32'hFFFF_FFFE, 32'd3},
            64'h0000_0001_FFFE_0003);

    // ---- rounding, shift=4, lanes {8,7,-8,-9} -> {1,0,0,-1}
`ifdef MATMUL_WRITER_RELU_EN
    exp_w = 64'h0000_0000_0000_0001;
`else
    exp_w = 64'hFFFF_0000_0000_0001;
`endif
    run_job("j2", 8'h40, 1, 5'd4,
            {32'hFFFF_FFF7, 32'hFFFF_FFF8, 32'd7, 32'd8}, exp_w);

    // ---- saturation, lanes {40000,-40000,32767,-32768}
`ifdef MATMUL_WRITER_RELU_EN
    exp_w = 64'h0000_7FFF_0000_7FFF;
`else
    exp_w = 64'h8000_7FFF_8000_7FFF;
`endif
    run_job("j3", 8'h20, 2, 5'd0,
            {32'hFFFF_8000, 32'h0000_7FFF, 32'hFFFF_63C0, 32'h0000_9C40}, exp_w);

    // ---- shift=31 near full scale: needs 33-bit rounding arithmetic
    //      lanes {7FFFFFFF, 80000000, 40000000, BFFFFFFF} -> {1,-1,1,-1}
`ifdef MATMUL_WRITER_RELU_EN
    exp_w = 64'h0000_0001_0000_0001;
`else
    exp_w = 64'hFFFF_0001_FFFF_0001;
`endif
    run_job("j4", 8'h30, 1, 5'd31,
            {32'hBFFF_FFFF, 32'h4000_0000, 32'h8000_0000, 32'h7FFF_FFFF}, exp_w);

    // ---- address wrap with bubbles, plus a start pulse while busy.
    //      valid in cycles 1,3,5 -> accepts at edges 2,4,6 -> writes in
    //      cycles 3,5,7 at FE,FF,00; done in cycle 9.
    @(negedge clk);
    start = 1'b1; base_addr = 8'hFE; num_rows = 8'd3; shift = 5'd0;
    in_valid = 1'b0; in_data = '0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk("wrap busy",     64'(busy),     64'(c <= 8));
      chk("wrap in_ready", 64'(in_ready), 64'(c <= 5));
      chk("wrap done",     64'(done),     64'(c == 9));
      chk("wrap mem_we",   64'(mem_we),   64'(c == 3 || c == 5 || c == 7));
      if (c == 3 || c == 5 || c == 7) begin
        ea4    = 8'hFE + 8'((c - 3) / 2);
        lane_v = 16'((c - 1) / 2);
        chk("wrap mem_addr",  64'(mem_addr), 64'(ea4));
        chk("wrap mem_wdata", mem_wdata,     {4{lane_v}});
      end
      // drive for the next edge
      start = (c == 3);
      if (c == 3) begin
        base_addr = 8'h55;
        num_rows  = 8'd9;
      end
      if (c == 1 || c == 3 || c == 5) begin
        in_valid = 1'b1;
        in_data  = {4{32'((c + 1) / 2)}};
      end else if (c >= 6) begin
        in_valid = 1'b1;
        in_data  = {4{32'd99}};
      end else begin
        in_valid = 1'b0;
        in_data  = '0;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;

    // ---- empty job: done one cycle after the start edge, no writes
    @(negedge clk);
    start = 1'b1; base_addr = 8'h77; num_rows = 8'd0; shift = 5'd0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk("zero done",     64'(done),     64'(c == 1));
      chk("zero busy",     64'(busy),     64'd0);
      chk("zero mem_we",   64'(mem_we),   64'd0);
      chk("zero in_ready", 64'(in_ready), 64'd0);
    end

    // ---- reset mid-job after 2 of 8 beats
    @(negedge clk);
    start = 1'b1; base_addr = 8'h80; num_rows = 8'd8; shift = 5'd0;
    in_data = {32'd0, 32'd1, 32'hFFFF_FFFE, 32'd3};
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
    end
    chk("midrst pre mem_we",   64'(mem_we),   64'd1);
    chk("midrst pre mem_addr", 64'(mem_addr), 64'h80);
    n_rst = 1'b0;
    #1;
    chk_idle_outputs("midrst async");
    @(negedge clk);
    n_rst = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("midrst after mem_we",   64'(mem_we),   64'd0);
      chk("midrst after busy",     64'(busy),     64'd0);
      chk("midrst after in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_result_writer.md
Name: matmul_result_writer

Overview:
- Downstream stage of the 4x4 systolic matrix-multiply unit. Consumes its 128-bit result beats, each holding four signed 32-bit lane accumulators.
- Requantizes each lane: arithmetic right shift with round-half-up, then saturate to signed 16-bit.
- Packs the four 16-bit results into one 64-bit word and writes it to the shared 8-bit-addressed result BRAM.
- Sequenced by a start/busy/done FSM and a valid/ready input handshake.

Parameters:
- LANES, 4, lanes per input beat; fixed at 4, other values unsupported.
- ACC_W, 32, width of each signed input lane.
- OUT_W, 16, width of each signed output lane (LANES*OUT_W = 64).
- ADDR_W, 8, result memory address width.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; latches base_addr, num_rows and shift.
- base_addr  input  8  first write address.
- num_rows  input  8  number of beats to process.
- shift  input  5  right-shift amount, 0..31.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  128  lane i = in_data[32i+31:32i], signed.
- mem_we  output  1  write strobe.
- mem_addr  output  8  write address.
- mem_wdata  output  64  lane i = mem_wdata[16i+15:16i].
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, n_rst low): FSM to IDLE; in_ready, mem_we, busy, done = 0; mem_addr = 0; mem_wdata = 0; counters and pipeline valids cleared. Reset mid-operation abandons the job; no further writes occur.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE, on start: latch base_addr, num_rows and shift. Go to DONE if num_rows == 0, else RUN. start is ignored in every other state.
- RUN:
  - in_ready = 1 while the accepted count < num_rows.
  - A beat is accepted when in_valid && in_ready.
  - When the last beat is accepted, go to DRAIN.
- DRAIN: in_ready = 0. Go to DONE once both pipeline valids are 0.
- DONE: done = 1 for exactly one cycle, busy drops in the same cycle, then return to IDLE.
- Pipeline stage 1 (registered):
  - Compute per lane in 33-bit signed arithmetic to avoid overflow.
  - shift == 0: r = x.
  - shift > 0: r = (x + (1 << (shift-1))) >>> shift.
- Pipeline stage 2 (registered): saturate r to [-32768, 32767] and pack. Drive mem_we = 1, mem_addr = current address, mem_wdata = packed word.
- Latency: a beat accepted at the cycle-N edge produces mem_we high in cycle N+2. Sustained throughput is 1 beat per cycle with no bubbles.
- Address:
  - First write goes to base_addr; each write then increments the address by 1.
  - Wraps from 8'hFF to 8'h00 without error.
  - Only addresses base_addr .. base_addr+num_rows-1 (mod 256) are written.
- in_valid low while in RUN inserts bubbles: no write occurs for empty pipeline slots, and the address does not advance on bubbles.
- mem_wdata holds its last value when mem_we is 0.
- Exactly num_rows writes occur per job.

Optional Feature:
- Macro: MATMUL_WRITER_RELU_EN.
- Defined: ReLU is applied after rounding and before saturation, so negative lanes become 0. Output range is [0, 32767].
- Undefined: no ReLU; the full signed saturation range applies. Port list is identical in both builds.

Test Plan:
- Reset, then start with base_addr=8'h10, num_rows=4, shift=0, lanes {3,-2,1,0}, in_valid held high -> writes at 8'h10..8'h13 to each beat, mem_wdata=64'h0000_0001_FFFE_0003. Each write lands 2 cycles after its accept. done pulses once, 1 cycle after the DRAIN exit condition is met.
- shift=4, lanes {8, 7, -8, -9} -> outputs {1, 0, 0, -1} (0x0001, 0x0000, 0x0000, 0xFFFF). With MATMUL_WRITER_RELU_EN, -1 becomes 0.
- Saturation check, shift=0, lanes {40000, -40000, 32767, -32768} -> {0x7FFF, 0x8000, 0x7FFF, 0x8000}. With MATMUL_WRITER_RELU_EN, the second and fourth lanes become 0x0000.
- base_addr=8'hFE, num_rows=3, in_valid toggling 1,0,1,0,1 -> writes at FE, FF, 00 with no extra writes. in_ready drops after the 3rd accept. A start pulse while busy is ignored.
- num_rows=0 -> no mem_we, done one cycle after the start edge. Separately, assert n_rst low after 2 of 8 beats -> all outputs 0 immediately and no further writes after release.
